mem_stage: RTL and testbench

Memory-access stage of the five-stage RISC-V pipeline, directly downstream of the execute stage. It consumes the EX/MEM pipeline register outputs and drives a ready-handshaked data-memory port with byte enables. It sign- or zero-extends load data and registers everything the write-back stage needs into the MEM/WB pipeline register. It stalls the pipeline while memory is not ready.

---
 rtl/mem_stage.sv | 149 ++++++++++++++
 tb/tb_mem_stage.sv | 202 ++++++++++++++++++++
 2 files changed

// File: rtl/mem_stage.sv
// Memory-access stage: drives the data-memory handshake, extends load data and fills MEM/WB.
// Optional macro MEM_MISALIGN_CHECK_EN suppresses misaligned H/W accesses and pulses misalign_m.
module mem_stage (
  input  logic        clk,
  input  logic        reset,
  input  logic        regwrite_m,
  input  logic [1:0]  result_src_m,
  input  logic        memwrite_m,
  input  logic [2:0]  funct3_m,
  input  logic [31:0] alu_result_m,
  input  logic [31:0] writedata_m,
  input  logic [4:0]  rd_m,
  input  logic [31:0] pc_plus_4_m,
  input  logic        dmem_ready,
  input  logic [31:0] dmem_rdata,
  output logic        dmem_req,
  output logic        dmem_we,
  output logic [31:0] dmem_addr,
  output logic [31:0] dmem_wdata,
  output logic [3:0]  dmem_be,
  output logic        stall_m,
  output logic        misalign_m,
  output logic        mem_wb_regwrite,
  output logic [1:0]  mem_wb_result_src,
  output logic [31:0] mem_wb_alu_result,
  output logic [31:0] mem_wb_read_data,
  output logic [4:0]  mem_wb_rd,
  output logic [31:0] mem_wb_pc_plus_4
);

  localparam logic [0:0] IDLE = 1'b0;
  localparam logic [0:0] WAIT = 1'b1;

  logic [0:0]  state_reg, state_next;
  logic [1:0]  a;
  logic        access, suppressed;
  logic        size_b, size_h, is_unsigned;
  logic [7:0]  byte_sel;
  logic [15:0] half_sel;
  logic [31:0] load_ext;

  assign a      = alu_result_m[1:0];
  assign access = memwrite_m | (result_src_m == 2'b01);

  // Unlisted funct3 codes fall through to word access.
  always_comb begin
    size_b      = 1'b0;
    size_h      = 1'b0;
    is_unsigned = 1'b0;
    case (funct3_m)
      3'b000: size_b = 1'b1;
      3'b001: size_h = 1'b1;
      3'b100: begin size_b = 1'b1; is_unsigned = 1'b1; end
      3'b101: begin size_h = 1'b1; is_unsigned = 1'b1; end
      default: ;
    endcase
  end

`ifdef MEM_MISALIGN_CHECK_EN
  assign suppressed = access & ((size_h & a[0]) | (~size_b & ~size_h & (a != 2'b00)));
`else
  assign suppressed = 1'b0;
`endif

  assign dmem_req  = access & ~reset & ~suppressed;
  assign dmem_we   = memwrite_m;
  assign dmem_addr = {alu_result_m[31:2], 2'b00};
  assign stall_m   = access & ~dmem_ready & ~suppressed & ~reset;

  always_comb begin
    if (size_b) begin
      dmem_be    = 4'b0001 << a;
      dmem_wdata = {4{writedata_m[7:0]}};
    end else if (size_h) begin
      dmem_be    = 4'b0011 << {a[1], 1'b0};
      dmem_wdata = {2{writedata_m[15:0]}};
    end else begin
      dmem_be    = 4'b1111;
      dmem_wdata = writedata_m;
    end
  end

  always_comb begin
    case (a)
      2'b00:   byte_sel = dmem_rdata[7:0];
      2'b01:   byte_sel = dmem_rdata[15:8];
      2'b10:   byte_sel = dmem_rdata[23:16];
      default: byte_sel = dmem_rdata[31:24];
    endcase
    half_sel = a[1] ? dmem_rdata[31:16] : dmem_rdata[15:0];
    if (size_b)
      load_ext = {{24{byte_sel[7] & ~is_unsigned}}, byte_sel};
    else if (size_h)
      load_ext = {{16{half_sel[15] & ~is_unsigned}}, half_sel};
    else
      load_ext = dmem_rdata;
  end

  // WAIT only tracks an outstanding request; upstream is frozen so inputs stay stable.
  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE:    if (dmem_req && !dmem_ready) state_next = WAIT;
      WAIT:    if (dmem_ready) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg         <= IDLE;
      mem_wb_regwrite   <= 1'b0;
      mem_wb_result_src <= 2'b00;
      mem_wb_alu_result <= '0;
      mem_wb_read_data  <= '0;
      mem_wb_rd         <= '0;
      mem_wb_pc_plus_4  <= '0;
    end else begin
      state_reg <= state_next;
      if (stall_m) begin
        mem_wb_regwrite   <= 1'b0;
        mem_wb_result_src <= 2'b00;
        mem_wb_alu_result <= '0;
        mem_wb_read_data  <= '0;
        mem_wb_rd         <= '0;
        mem_wb_pc_plus_4  <= '0;
      end else begin
        mem_wb_regwrite   <= regwrite_m & ~suppressed;
        mem_wb_result_src <= result_src_m;
        mem_wb_alu_result <= alu_result_m;
        mem_wb_read_data  <= load_ext;
        mem_wb_rd         <= rd_m;
        mem_wb_pc_plus_4  <= pc_plus_4_m;
      end
    end
  end

`ifdef MEM_MISALIGN_CHECK_EN
  logic misalign_reg;
  always_ff @(posedge clk) begin
    if (reset) misalign_reg <= 1'b0;
    else       misalign_reg <= suppressed;
  end
  assign misalign_m = misalign_reg;
`else
  assign misalign_m = 1'b0;
`endif

endmodule

// File: tb/tb_mem_stage.sv
// Bench for mem_stage: directed cases plus random transactions against an arithmetic reference model.
module tb_mem_stage;
  logic        clk = 1'b0;
  logic        reset;
  logic        regwrite_m;
  logic [1:0]  result_src_m;
  logic        memwrite_m;
  logic [2:0]  funct3_m;
  logic [31:0] alu_result_m, writedata_m, pc_plus_4_m;
  logic [4:0]  rd_m;
  logic        dmem_ready;
  logic [31:0] dmem_rdata;
  logic        dmem_req, dmem_we, stall_m, misalign_m;
  logic [31:0] dmem_addr, dmem_wdata;
  logic [3:0]  dmem_be;
  logic        mem_wb_regwrite;
  logic [1:0]  mem_wb_result_src;
  logic [31:0] mem_wb_alu_result, mem_wb_read_data, mem_wb_pc_plus_4;
  logic [4:0]  mem_wb_rd;

  int total = 0;
  int passes = 0;
  int fails = 0;

  always #5 clk = ~clk;

  mem_stage dut (
    .clk(clk), .reset(reset), .regwrite_m(regwrite_m), .result_src_m(result_src_m),
    .memwrite_m(memwrite_m), .funct3_m(funct3_m), .alu_result_m(alu_result_m),
    .writedata_m(writedata_m), .rd_m(rd_m), .pc_plus_4_m(pc_plus_4_m),
    .dmem_ready(dmem_ready), .dmem_rdata(dmem_rdata), .dmem_req(dmem_req),
    .dmem_we(dmem_we), .dmem_addr(dmem_addr), .dmem_wdata(dmem_wdata), .dmem_be(dmem_be),
    .stall_m(stall_m), .misalign_m(misalign_m), .mem_wb_regwrite(mem_wb_regwrite),
    .mem_wb_result_src(mem_wb_result_src), .mem_wb_alu_result(mem_wb_alu_result),
    .mem_wb_read_data(mem_wb_read_data), .mem_wb_rd(mem_wb_rd),
    .mem_wb_pc_plus_4(mem_wb_pc_plus_4)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passes++;
    else begin
      fails++;
      $error("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  // Reference model: access width in bytes, lane offset, and extraction by shifting.
  function automatic int acc_size(input logic [2:0] f);
    case (f[1:0])
      2'b00:   return 1;
      2'b01:   return 2;
      default: return 4;
    endcase
  endfunction

  function automatic int lane_off(input int s, input logic [1:0] a);
    if (s == 1) return int'(a);
    if (s == 2) return int'(a) & 2;
    return 0;
  endfunction

  function automatic logic [31:0] model_load(input logic [2:0] f, input logic [1:0] a, input logic [31:0] w);
    int s;
    logic [31:0] v, mask;
    s    = acc_size(f);
    v    = w >> (8 * lane_off(s, a));
    mask = (s == 4) ? 32'hFFFF_FFFF : ((32'd1 << (8 * s)) - 32'd1);
    v    = v & mask;
    if (s < 4 && !f[2] && v[8*s-1]) v = v | ~mask;
    return v;
  endfunction

  function automatic logic [31:0] model_wdata(input int s, input logic [31:0] wd);
    logic [31:0] r;
    r = '0;
    for (int i = 0; i < 4; i++) r[8*i +: 8] = wd[8*(i % s) +: 8];
    return r;
  endfunction

  // op: 0 = ALU, 1 = load, 2 = store, 3 = pc+4
  task automatic run_txn(input int op, input logic [2:0] f3, input logic [31:0] addr,
                         input logic [31:0] wd, input logic [31:0] rword, input int waits);
    logic        rw, acc, mis;
    logic [1:0]  rs;
    logic [4:0]  rdv;
    logic [31:0] pc4;
    logic [3:0]  be_exp;
    int          s, ew;
    rw  = 1'($urandom);
    rdv = 5'($urandom);
    pc4 = $urandom;
    rs  = (op == 1) ? 2'b01 : (op == 3) ? 2'b10 : (op == 0 && $urandom_range(0, 1) == 1) ? 2'b11 : 2'b00;
    acc = (op == 1) || (op == 2);
    s   = acc_size(f3);
`ifdef MEM_MISALIGN_CHECK_EN
    mis = acc && ((s == 2 && addr[0]) || (s == 4 && addr[1:0] != 2'b00));
`else
    mis = 1'b0;
`endif
    ew     = (acc && !mis) ? waits : 0;
    be_exp = 4'(((1 << s) - 1) << lane_off(s, addr[1:0]));
    for (int k = 0; k <= ew; k++) begin
      @(negedge clk);
      regwrite_m   = rw;
      result_src_m = rs;
      memwrite_m   = (op == 2);
      funct3_m     = f3;
      alu_result_m = addr;
      writedata_m  = wd;
      rd_m         = rdv;
      pc_plus_4_m  = pc4;
      dmem_ready   = (acc && !mis) ? (k == ew) : 1'($urandom);
      dmem_rdata   = (k == ew) ? rword : $urandom;
      #2;
      check("req", 32'(dmem_req), 32'(acc && !mis));
      check("stall", 32'(stall_m), 32'(k < ew));
      if (acc && !mis) begin
        check("addr", dmem_addr, addr & 32'hFFFF_FFFC);
        check("be", 32'(dmem_be), 32'(be_exp));
        check("we", 32'(dmem_we), 32'(op == 2));
        if (op == 2) check("wdata", dmem_wdata, model_wdata(s, wd));
      end
      @(posedge clk);
      #1;
      if (k < ew) begin
        check("bubble_rw", 32'(mem_wb_regwrite), 32'd0);
        check("bubble_rs", 32'(mem_wb_result_src), 32'd0);
      end else begin
        check("wb_rw", 32'(mem_wb_regwrite), 32'(rw && !mis));
        check("wb_rs", 32'(mem_wb_result_src), 32'(rs));
        check("wb_alu", mem_wb_alu_result, addr);
        check("wb_rdata", mem_wb_read_data, model_load(f3, addr[1:0], rword));
        check("wb_rd", 32'(mem_wb_rd), 32'(rdv));
        check("wb_pc4", mem_wb_pc_plus_4, pc4);
      end
      check("misalign", 32'(misalign_m), 32'(mis && k == ew));
    end
    $display("txn op=%0d f3=%0d addr=%h waits=%0d mis=%0d", op, f3, addr, ew, mis);
  endtask

  initial begin
    logic [2:0] f3_tab [8];
    f3_tab = '{3'b000, 3'b001, 3'b010, 3'b100, 3'b101, 3'b011, 3'b110, 3'b111};

    // Reset with an access requested and memory ready.
    reset = 1'b1; regwrite_m = 1'b1; result_src_m = 2'b01; memwrite_m = 1'b1;
    funct3_m = 3'b010; alu_result_m = 32'h100; writedata_m = 32'h55; rd_m = 5'd3;
    pc_plus_4_m = 32'h44; dmem_ready = 1'b1; dmem_rdata = 32'h1234_5678;
    @(negedge clk); #2;
    check("rst_req", 32'(dmem_req), 32'd0);
    check("rst_stall", 32'(stall_m), 32'd0);
    @(posedge clk); #1;
    check("rst_wb_rw", 32'(mem_wb_regwrite), 32'd0);
    check("rst_wb_rs", 32'(mem_wb_result_src), 32'd0);
    check("rst_wb_alu", mem_wb_alu_result, 32'd0);
    check("rst_wb_rdata", mem_wb_read_data, 32'd0);
    check("rst_wb_rd", 32'(mem_wb_rd), 32'd0);
    check("rst_wb_pc4", mem_wb_pc_plus_4, 32'd0);
    check("rst_misalign", 32'(misalign_m), 32'd0);
    @(negedge clk); reset = 1'b0;
    $display("txn reset done");

    // Directed: LB / LBU at 0x103, SH at 0x202, LW with three wait cycles.
    run_txn(1, 3'b000, 32'h103, 32'h0, 32'h80FF_0000, 0);
    check("lb_const", mem_wb_read_data, 32'hFFFF_FF80);
    run_txn(1, 3'b100, 32'h103, 32'h0, 32'h80FF_0000, 0);
    check("lbu_const", mem_wb_read_data, 32'h0000_0080);
    run_txn(2, 3'b001, 32'h202, 32'h1234_ABCD, 32'h0, 0);
    run_txn(1, 3'b010, 32'h300, 32'h0, 32'hDEAD_BEEF, 3);
    check("lw_const", mem_wb_read_data, 32'hDEAD_BEEF);
    run_txn(1, 3'b010, 32'h101, 32'h0, 32'hCAFE_F00D, 0);

    // Reset asserted in the second WAIT cycle abandons the load.
    @(negedge clk);
    regwrite_m = 1'b1; result_src_m = 2'b01; memwrite_m = 1'b0; funct3_m = 3'b010;
    alu_result_m = 32'h40; rd_m = 5'd7; dmem_ready = 1'b0;
    #2;
    check("rw_stall1", 32'(stall_m), 32'd1);
    @(negedge clk); reset = 1'b1;
    #2;
    check("rw_req", 32'(dmem_req), 32'd0);
    check("rw_stall2", 32'(stall_m), 32'd0);
    @(posedge clk); #1;
    check("rw_wb_rw", 32'(mem_wb_regwrite), 32'd0);
    check("rw_wb_rd", 32'(mem_wb_rd), 32'd0);
    @(negedge clk); reset = 1'b0; result_src_m = 2'b00; dmem_ready = 1'b1;
    #2;
    check("rw_idle_stall", 32'(stall_m), 32'd0);
    check("rw_idle_req", 32'(dmem_req), 32'd0);
    $display("txn reset-in-wait done");

    // Random traffic, back to back.
    for (int n = 0; n < 80; n++) begin
      run_txn(int'($urandom_range(0, 3)), f3_tab[$urandom_range(0, 7)], $urandom,
              $urandom, $urandom, int'($urandom_range(0, 3)));
    end

    $display("%0d/%0d checks passed", passes, total);
    $finish;
  end
endmodule
